// File: rtl/div_pkg.sv
// Shared types and constants for the divide issue controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    COOL = 2'd3
  } state_t;

  // RV32M divide-family funct3 encodings.
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_special_detect.sv
// Detects divide ops whose RISC-V result is architecturally fixed (x/0, INT_MIN/-1 signed).
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever operands are presented.
// Ports: rs1/rs2 operands, funct3 op code -> is_special flag and the fixed special_result.
module div_special_detect
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            is_special,
  output logic [XLEN-1:0] special_result
);

  logic div_by_zero;
  logic signed_ovf;
  logic is_signed_op;

  assign is_signed_op = (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign div_by_zero  = (rs2 == '0);
  assign signed_ovf   = is_signed_op && (rs1 == INT_MIN) && (rs2 == ALL_ONES);

  always_comb begin
    is_special     = div_by_zero || signed_ovf;
    special_result = '0;
    if (div_by_zero) begin
      // Quotient saturates to all ones; remainder is the untouched dividend.
      special_result = funct3[1] ? rs1 : ALL_ONES;
    end else if (signed_ovf) begin
      special_result = funct3[1] ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer for the 32-cycle sequential divider: latches a DIV/DIVU/REM/REMU op, runs it, returns one writeback beat.
// Latency: special cases (and cache hits) wb_valid 2 cycles after accept; divider path wb_valid 2 cycles after div_done.
// Backpressure: req_ready only in IDLE; busy stalls the pipeline from accept through the cool-down cycle.
// Ports: clk/reset_n; req_* request handshake; flush kill; busy; wb_* result beat;
//        div_* drive/capture the external divider (enable, sign select, operands, done, quotient, remainder).
// Optional: define DIV_RESULT_CACHE_EN to keep the last divider result and serve a matching op without the divider.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_funct3,
  input  logic [XLEN-1:0]      req_rs1,
  input  logic [XLEN-1:0]      req_rs2,
  input  logic [REGADDR_W-1:0] req_rd,
  input  logic                 flush,
  output logic                 busy,
  output logic                 wb_valid,
  output logic [REGADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 div_enable,
  output logic                 div_sign_sel,
  output logic [XLEN-1:0]      div_numA,
  output logic [XLEN-1:0]      div_denB,
  input  logic                 div_done,
  input  logic [XLEN-1:0]      div_quotient,
  input  logic [XLEN-1:0]      div_remainder
);

  state_t state_q, state_d;

  logic                 accept;
  logic                 is_special;
  logic [XLEN-1:0]      special_result;
  logic                 cache_hit;
  logic [XLEN-1:0]      cache_result;
  logic                 rem_sel_q;
  logic [REGADDR_W-1:0] rd_q;
  logic [XLEN-1:0]      res_q;
  logic                 div_finish;

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  // A flush in the same cycle blocks acceptance so a killed op never starts.
  assign accept     = req_valid && req_ready && !flush;
  // Flush has priority over a coincident done pulse.
  assign div_finish = (state_q == RUN) && div_done && !flush;

  div_special_detect #(.XLEN(XLEN)) u_special (
    .rs1            (req_rs1),
    .rs2            (req_rs2),
    .funct3         (req_funct3),
    .is_special     (is_special),
    .special_result (special_result)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_vld;
  logic            cache_sign;
  logic [XLEN-1:0] cache_a;
  logic [XLEN-1:0] cache_b;
  logic [XLEN-1:0] cache_q;
  logic [XLEN-1:0] cache_r;

  assign cache_hit    = cache_vld && (cache_sign == req_funct3[0]) &&
                        (cache_a == req_rs1) && (cache_b == req_rs2);
  assign cache_result = req_funct3[1] ? cache_r : cache_q;

  // Only completed divider runs are stored, so flush never invalidates the entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_vld  <= 1'b0;
      cache_sign <= 1'b0;
      cache_a    <= '0;
      cache_b    <= '0;
      cache_q    <= '0;
      cache_r    <= '0;
    end else if (div_finish) begin
      cache_vld  <= 1'b1;
      cache_sign <= div_sign_sel;
      cache_a    <= div_numA;
      cache_b    <= div_denB;
      cache_q    <= div_quotient;
      cache_r    <= div_remainder;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (is_special || cache_hit) ? RESP : RUN;
      end
      RUN: begin
        if (flush)         state_d = COOL;
        else if (div_done) state_d = RESP;
      end
      RESP:    state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_enable   <= 1'b0;
      div_sign_sel <= 1'b0;
      div_numA     <= '0;
      div_denB     <= '0;
      rem_sel_q    <= 1'b0;
      rd_q         <= '0;
      res_q        <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      if (accept) begin
        div_sign_sel <= req_funct3[0];
        rem_sel_q    <= req_funct3[1];
        div_numA     <= req_rs1;
        div_denB     <= req_rs2;
        rd_q         <= req_rd;
        if (is_special)     res_q <= special_result;
        else if (cache_hit) res_q <= cache_result;
        div_enable <= !(is_special || cache_hit);
      end

      if (state_q == RUN && (flush || div_done)) div_enable <= 1'b0;
      if (div_finish) res_q <= rem_sel_q ? div_remainder : div_quotient;

      // The result beat is registered out of RESP, which lands it in the COOL cycle.
      wb_valid <= (state_q == RESP) && !flush;
      if ((state_q == RESP) && !flush) begin
        wb_rd   <= rd_q;
        wb_data <= res_q;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural 32-cycle divider.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_issue_ctrl;

  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        div_enable;
  logic        div_sign_sel;
  logic [31:0] div_numA;
  logic [31:0] div_denB;
  logic        div_done;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_remainder = '0;
  logic        model_done = 1'b0;
  logic        stray_done;
  int          mdl_cnt = 0;

  int checks = 0;
  int errors = 0;

  // Observations from one op
  logic [31:0] o_data;
  logic [4:0]  o_rd;
  int          o_done_k, o_wb_k, o_en_cyc, o_pulses, o_busy_gaps;
  logic        o_sign, o_rdy_at_wb, o_rdy_after, o_busy_at_wb, o_en_at_wb;
  logic [31:0] o_numa, o_denb;

  always #5 clk = ~clk;

  assign div_done = model_done | stray_done;

  div_issue_ctrl #(.XLEN(32), .REGADDR_W(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_funct3    (req_funct3),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_rd        (req_rd),
    .flush         (flush),
    .busy          (busy),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .div_enable    (div_enable),
    .div_sign_sel  (div_sign_sel),
    .div_numA      (div_numA),
    .div_denB      (div_denB),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  // Behavioural divider: pulses done DIV_LAT cycles after enable rises, clears when enable drops.
  always @(posedge clk) begin
    if (div_enable) begin
      mdl_cnt    <= mdl_cnt + 1;
      model_done <= (mdl_cnt == DIV_LAT - 1);
      if (div_sign_sel) begin
        div_quotient  <= div_numA / div_denB;
        div_remainder <= div_numA % div_denB;
      end else begin
        div_quotient  <= $signed(div_numA) / $signed(div_denB);
        div_remainder <= $signed(div_numA) % $signed(div_denB);
      end
    end else begin
      mdl_cnt    <= 0;
      model_done <= 1'b0;
    end
  end

  // Issue one op at a negedge (k=0) and observe the following negedges.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    o_data = '0; o_rd = '0; o_done_k = -1; o_wb_k = -1; o_en_cyc = 0; o_pulses = 0;
    o_busy_gaps = 0; o_sign = 1'b0; o_rdy_at_wb = 1'bx; o_rdy_after = 1'bx;
    o_busy_at_wb = 1'bx; o_en_at_wb = 1'bx; o_numa = '0; o_denb = '0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        o_sign = div_sign_sel; o_numa = div_numA; o_denb = div_denB;
      end
      if (div_enable) o_en_cyc++;
      if (div_done && o_done_k < 0) o_done_k = k;
      if (!busy && o_wb_k < 0) o_busy_gaps++;
      if (wb_valid) begin
        o_pulses++;
        if (o_wb_k < 0) begin
          o_wb_k = k; o_data = wb_data; o_rd = wb_rd;
          o_rdy_at_wb = req_ready; o_busy_at_wb = busy; o_en_at_wb = div_enable;
        end
      end
      if (o_wb_k >= 0 && k == o_wb_k + 1) o_rdy_after = req_ready;
      if (o_wb_k >= 0 && k == o_wb_k + 3) break;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (div_enable !== 1'b0) begin errors++; $display("FAIL reset_div_enable: got %b want 0", div_enable); end
    checks++; if ({wb_rd, wb_data} !== 37'd0) begin errors++; $display("FAIL reset_wb_fields: got rd=%h data=%h want 0", wb_rd, wb_data); end
    checks++; if ({div_sign_sel, div_numA, div_denB} !== 65'd0) begin errors++; $display("FAIL reset_div_fields: got sel=%b a=%h b=%h want 0", div_sign_sel, div_numA, div_denB); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_divu;
    do_op(3'b101, 32'd100, 32'd7, 5'd3);
    checks++; if (o_data !== 32'd14) begin errors++; $display("FAIL divu_data: got %h want %h", o_data, 32'd14); end
    checks++; if (o_rd !== 5'd3) begin errors++; $display("FAIL divu_rd: got %0d want 3", o_rd); end
    checks++; if (o_pulses !== 1) begin errors++; $display("FAIL divu_pulses: got %0d want 1", o_pulses); end
    checks++; if (o_sign !== 1'b1) begin errors++; $display("FAIL divu_sign_sel: got %b want 1", o_sign); end
    checks++; if ({o_numa, o_denb} !== {32'd100, 32'd7}) begin errors++; $display("FAIL divu_operands: got %h/%h want 64/7", o_numa, o_denb); end
    checks++; if (o_done_k !== 33) begin errors++; $display("FAIL divu_done_k: got %0d want 33", o_done_k); end
    checks++; if (o_en_cyc !== 33) begin errors++; $display("FAIL divu_enable_held: got %0d cycles want 33", o_en_cyc); end
    checks++; if (o_wb_k !== 35) begin errors++; $display("FAIL divu_wb_latency: got %0d want 35", o_wb_k); end
    checks++; if (o_en_at_wb !== 1'b0) begin errors++; $display("FAIL divu_enable_cool: got %b want 0", o_en_at_wb); end
    checks++; if (o_busy_at_wb !== 1'b1) begin errors++; $display("FAIL divu_busy_cool: got %b want 1", o_busy_at_wb); end
    checks++; if (o_rdy_at_wb !== 1'b0) begin errors++; $display("FAIL divu_ready_cool: got %b want 0", o_rdy_at_wb); end
    checks++; if (o_rdy_after !== 1'b1) begin errors++; $display("FAIL divu_ready_after: got %b want 1", o_rdy_after); end
  endtask

  task automatic test_div_signed;
    do_op(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd7);
    checks++; if (o_data !== 32'hFFFF_FFFA) begin errors++; $display("FAIL div_neg_data: got %h want fffffffa", o_data); end
    checks++; if (o_sign !== 1'b0) begin errors++; $display("FAIL div_neg_sign_sel: got %b want 0", o_sign); end
    checks++; if (o_busy_gaps !== 0) begin errors++; $display("FAIL div_neg_busy_gap: got %0d idle cycles want 0", o_busy_gaps); end
    checks++; if (o_wb_k !== 35) begin errors++; $display("FAIL div_neg_wb_latency: got %0d want 35", o_wb_k); end
  endtask

  task automatic test_div_by_zero;
    do_op(3'b100, 32'd5, 32'd0, 5'd9);
    checks++; if (o_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_data: got %h want ffffffff", o_data); end
    checks++; if (o_wb_k !== 2) begin errors++; $display("FAIL div0_latency: got %0d want 2", o_wb_k); end
    checks++; if (o_en_cyc !== 0) begin errors++; $display("FAIL div0_enable: got %0d cycles want 0", o_en_cyc); end
    checks++; if (o_rd !== 5'd9 || o_pulses !== 1) begin errors++; $display("FAIL div0_beat: got rd=%0d pulses=%0d want 9/1", o_rd, o_pulses); end
    do_op(3'b111, 32'd5, 32'd0, 5'd10);
    checks++; if (o_data !== 32'd5) begin errors++; $display("FAIL remu0_data: got %h want 5", o_data); end
    checks++; if (o_en_cyc !== 0) begin errors++; $display("FAIL remu0_enable: got %0d cycles want 0", o_en_cyc); end
    do_op(3'b101, 32'd5, 32'd0, 5'd11);
    checks++; if (o_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_data: got %h want ffffffff", o_data); end
    do_op(3'b110, 32'd5, 32'd0, 5'd12);
    checks++; if (o_data !== 32'd5) begin errors++; $display("FAIL rem0_data: got %h want 5", o_data); end
  endtask

  task automatic test_overflow;
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    checks++; if (o_data !== 32'd0) begin errors++; $display("FAIL ovf_rem_data: got %h want 0", o_data); end
    checks++; if (o_en_cyc !== 0 || o_wb_k !== 2) begin errors++; $display("FAIL ovf_rem_path: got en=%0d wb_k=%0d want 0/2", o_en_cyc, o_wb_k); end
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    checks++; if (o_data !== 32'h8000_0000) begin errors++; $display("FAIL ovf_div_data: got %h want 80000000", o_data); end
    checks++; if (o_en_cyc !== 0) begin errors++; $display("FAIL ovf_div_enable: got %0d want 0", o_en_cyc); end
    // Unsigned is not an overflow case and must go through the divider.
    do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    checks++; if (o_data !== 32'd0 || o_en_cyc !== 33) begin errors++; $display("FAIL ovf_divu: got data=%h en=%0d want 0/33", o_data, o_en_cyc); end
  endtask

  task automatic test_flush_run;
    int wb_seen;
    wb_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd17; req_rs2 = 32'd5; req_rd = 5'd6;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (div_enable !== 1'b0) begin errors++; $display("FAIL flush_run_enable: got %b want 0", div_enable); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_run_cool: got busy=%b want 1", busy); end
    if (wb_valid) wb_seen++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_run_idle: got busy=%b want 0", busy); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wb_valid) wb_seen++;
    end
    checks++; if (wb_seen !== 0) begin errors++; $display("FAIL flush_run_no_wb: got %0d beats want 0", wb_seen); end
    do_op(3'b111, 32'd17, 32'd5, 5'd6);
    checks++; if (o_data !== 32'd2 || o_pulses !== 1) begin errors++; $display("FAIL flush_run_next: got data=%h pulses=%0d want 2/1", o_data, o_pulses); end
  endtask

  task automatic test_flush_resp;
    int wb_seen;
    wb_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd5; req_rs2 = 32'd0; req_rd = 5'd8;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (wb_valid) wb_seen++;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_resp_cool: got busy=%b want 1", busy); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wb_valid) wb_seen++;
    end
    checks++; if (wb_seen !== 0) begin errors++; $display("FAIL flush_resp_no_wb: got %0d beats want 0", wb_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_resp_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_flush_with_done;
    int wb_seen;
    bit seen_done;
    wb_seen = 0; seen_done = 0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd100; req_rs2 = 32'd7; req_rd = 5'd2;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (div_done) begin
        flush = 1'b1; seen_done = 1; break;
      end
    end
    checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL flush_done_timeout: got done=%b want 1", seen_done); end
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b1 || div_enable !== 1'b0) begin errors++; $display("FAIL flush_done_cool: got busy=%b en=%b want 1/0", busy, div_enable); end
    for (int k = 0; k < 6; k++) begin
      if (wb_valid) wb_seen++;
      @(negedge clk);
    end
    checks++; if (wb_seen !== 0) begin errors++; $display("FAIL flush_done_no_wb: got %0d beats want 0", wb_seen); end
  endtask

  task automatic test_flush_idle_req;
    int wb_seen;
    wb_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd9; req_rs2 = 32'd3; req_rd = 5'd1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0 || div_enable !== 1'b0) begin errors++; $display("FAIL flush_idle_accept: got busy=%b en=%b want 0/0", busy, div_enable); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wb_valid) wb_seen++;
    end
    checks++; if (wb_seen !== 0) begin errors++; $display("FAIL flush_idle_no_wb: got %0d beats want 0", wb_seen); end
  endtask

  task automatic test_stray_done;
    int wb_seen;
    wb_seen = 0;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stray_done_busy: got %b want 0", busy); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wb_valid) wb_seen++;
    end
    checks++; if (wb_seen !== 0) begin errors++; $display("FAIL stray_done_wb: got %0d beats want 0", wb_seen); end
  endtask

  task automatic test_cache_pair;
    do_op(3'b100, 32'd17, 32'd5, 5'd13);
    checks++; if (o_data !== 32'd3 || o_en_cyc !== 33) begin errors++; $display("FAIL pair_div: got data=%h en=%0d want 3/33", o_data, o_en_cyc); end
    do_op(3'b110, 32'd17, 32'd5, 5'd14);
    checks++; if (o_data !== 32'd2 || o_rd !== 5'd14) begin errors++; $display("FAIL pair_rem: got data=%h rd=%0d want 2/14", o_data, o_rd); end
`ifdef DIV_RESULT_CACHE_EN
    checks++; if (o_en_cyc !== 0 || o_wb_k !== 2) begin errors++; $display("FAIL pair_rem_cached: got en=%0d wb_k=%0d want 0/2", o_en_cyc, o_wb_k); end
`else
    checks++; if (o_en_cyc !== 33 || o_wb_k !== 35) begin errors++; $display("FAIL pair_rem_rerun: got en=%0d wb_k=%0d want 33/35", o_en_cyc, o_wb_k); end
`endif
  endtask

  task automatic test_reset_midop;
    int wb_seen, en_seen;
    wb_seen = 0; en_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b101; req_rs1 = 32'd100; req_rs2 = 32'd7; req_rd = 5'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (div_enable !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL reset_midop_abort: got en=%b busy=%b wb=%b want 0/0/0", div_enable, busy, wb_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wb_valid) wb_seen++;
      if (div_enable) en_seen++;
    end
    checks++; if (wb_seen !== 0 || en_seen !== 0) begin errors++; $display("FAIL reset_midop_quiet: got wb=%0d en=%0d want 0/0", wb_seen, en_seen); end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_funct3 = 3'b100; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; flush = 1'b0; stray_done = 1'b0;
    test_reset;
    test_divu;
    test_div_signed;
    test_div_by_zero;
    test_overflow;
    test_flush_run;
    test_flush_resp;
    test_flush_with_done;
    test_flush_idle_req;
    test_stray_done;
    test_cache_pair;
    test_reset_midop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
